standcell_tick_sched: RTL and testbench
=======================================

// Module: standcell_tick_sched
// PURPOSE
//  Run-control and timing-configuration block for the emulated discrete-logic array.
//  Produces TICK, the single-cycle enable that advances every standard-cell delay model.
//  Holds the tPHL/tPLH delay counts broadcast to all cells.
//  Lets the ARM side halt the array, free-run it, or single-step it N ticks via a 4-register write port.
// PARAMETERS
//  CNTW    10    width of PHLCNT/PLHCNT delay counts
//  PHLRST  39    reset value of PHLCNT (0.4uS at 10nS/tick)
//  PLHRST  399   reset value of PLHCNT (4uS at 10nS/tick)
//  DIVW    8     width of tick prescaler divisor
// PORTS
//  U          in   1     clock, all state on posedge
//  RESET      in   1     asynchronous, active-high reset
//  WREN       in   1     register write strobe, one write per cycle
//  WADDR      in   2     0=CTRL 1=STEPN 2=PHL 3=PLH
//  WDATA      in   16    write data
//  TICK       out  1     cell advance enable, one U cycle wide
//  RUNNING    out  1     1 while state is RUN or STEP
//  STEPDONE   out  1     one-cycle pulse when a STEP burst completes normally
//  PEND       out  1     PHL/PLH write pending, not yet applied
//  PHLCNT     out  CNTW  live high-to-low delay count to cells
//  PLHCNT     out  CNTW  live low-to-high delay count to cells
//  TICKCOUNT  out  32    total TICKs issued, wraps modulo 2^32
// BEHAVIOUR
//  Reset (async): state HALT; TICK=0, RUNNING=0, STEPDONE=0, PEND=0, TICKCOUNT=0.
//   PHLCNT=PHLRST, PLHCNT=PLHRST, DIV=0, STEPN=0, prescaler=0, step remaining=0.
//   Reset mid-burst abandons the burst with no STEPDONE.
//  CTRL write: WDATA[15:8]=DIV, [1]=STEP request (self-clearing), [0]=RUN.
//  STEPN write: loads 16-bit burst length; takes effect at the next STEP request.
//  Prescaler: counts 0..DIV. TICK is registered, high in the cycle after the count reaches DIV.
//   DIV=0 gives TICK every cycle. DIV=k gives one TICK per k+1 cycles.
//   Prescaler clears on every entry to RUN or STEP, so the first TICK comes DIV+1 cycles after the write.
//  States:
//   HALT: TICK=0, prescaler held at 0.
//    CTRL RUN=1 -> RUN.
//    RUN=0 with STEP=1 -> STEP, remaining=STEPN.
//    STEPN=0 -> stays HALT and pulses STEPDONE next cycle.
//   RUN: TICK at prescaler rate.
//    CTRL RUN=0 -> HALT next edge; a TICK due in that same cycle is suppressed.
//    STEP requests are ignored.
//   STEP: TICK at prescaler rate; remaining decrements on each TICK.
//    The TICK that takes remaining to 0 is the last; next cycle -> HALT with STEPDONE=1.
//    CTRL RUN=1 during STEP -> RUN, remaining discarded, no STEPDONE.
//    CTRL RUN=0 with STEP=0 during STEP -> HALT (abort), no STEPDONE.
//  PHL/PLH writes: value clamped to 2^CNTW-1 (WDATA above range -> all ones). Stored in a shadow; PEND=1.
//   In HALT the shadow applies on the next edge.
//   In RUN/STEP it applies on the edge after a TICK cycle, never coincident with TICK.
//   The application edge also clears PEND.
//   A second write before application overwrites the shadow; last write wins.
//   A write on the same edge as application: the new value stays pending.
//  TICKCOUNT increments on every TICK cycle, wrapping at 0xFFFFFFFF to 0.
//  STEPDONE is never asserted together with TICK.
// TESTING
//  Reset, no writes -> TICK=0, PHLCNT=39, PLHCNT=399, TICKCOUNT=0 for 100 cycles.
//  CTRL=0x0301 (DIV=3, RUN) -> TICK every 4th cycle, first at cycle 4; CTRL=0 -> TICK stops, RUNNING=0.
//  STEPN=5, CTRL=0x0002 -> exactly 5 TICKs one cycle apart, STEPDONE 1 cycle after 5th, TICKCOUNT=5.
//  STEPN=0, CTRL=0x0002 -> no TICK, STEPDONE pulse; CTRL=0x0002 while running -> ignored.
//  While running DIV=2: write PHL=0xFFFF -> PEND=1, PHLCNT becomes 1023 on edge after next TICK, PEND=0.
//  STEPN=100, start step, assert RESET after 10 TICKs -> all outputs at reset values, no STEPDONE.

Source files
------------

// File: rtl/standcell_tick_sched.sv
// Run-control and timing-configuration block for the emulated discrete-logic array.
// Generates TICK, the single-cycle advance enable shared by every standard-cell delay
// model. Holds the broadcast tPHL/tPLH counts. The ARM side can halt the array,
// free-run it, or step it a fixed number of ticks through a four-register write port.
module standcell_tick_sched #(
   parameter int CNTW   = 10,
   parameter int PHLRST = 39,
   parameter int PLHRST = 399,
   parameter int DIVW   = 8
) (
   input  logic            U,
   input  logic            RESET,
   input  logic            WREN,
   input  logic [1:0]      WADDR,
   input  logic [15:0]     WDATA,
   output logic            TICK,
   output logic            RUNNING,
   output logic            STEPDONE,
   output logic            PEND,
   output logic [CNTW-1:0] PHLCNT,
   output logic [CNTW-1:0] PLHCNT,
   output logic [31:0]     TICKCOUNT
);

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_e;

   localparam logic [1:0]  ADDR_CTRL  = 2'd0;
   localparam logic [1:0]  ADDR_STEPN = 2'd1;
   localparam logic [1:0]  ADDR_PHL   = 2'd2;
   localparam logic [1:0]  ADDR_PLH   = 2'd3;
   localparam logic [31:0] CNT_MAX    = (32'd1 << CNTW) - 32'd1;

   state_e            state_q,    state_d;
   logic [DIVW-1:0]   div_q,      div_d;
   logic [DIVW-1:0]   presc_q,    presc_d;
   logic [15:0]       stepn_q,    stepn_d;
   logic [15:0]       remain_q,   remain_d;
   logic              tick_q,     tick_d;
   logic              stepdone_q, stepdone_d;
   logic              pend_q,     pend_d;
   logic [CNTW-1:0]   phl_q,      phl_d;
   logic [CNTW-1:0]   plh_q,      plh_d;
   logic [CNTW-1:0]   phl_sh_q,   phl_sh_d;
   logic [CNTW-1:0]   plh_sh_q,   plh_sh_d;
   logic [31:0]       tcount_q,   tcount_d;

   logic              wr_ctrl, wr_stepn, wr_phl, wr_plh;
   logic              ctrl_run, ctrl_step;
   logic              tick_due;
   logic [CNTW-1:0]   wr_cnt;

   assign wr_ctrl   = WREN && (WADDR == ADDR_CTRL);
   assign wr_stepn  = WREN && (WADDR == ADDR_STEPN);
   assign wr_phl    = WREN && (WADDR == ADDR_PHL);
   assign wr_plh    = WREN && (WADDR == ADDR_PLH);
   assign ctrl_run  = WDATA[0];
   assign ctrl_step = WDATA[1];
   // A current DIV below the running count (DIV lowered mid-run) still releases a tick.
   assign tick_due  = (presc_q >= div_q);

   // Saturate delay-count writes that exceed the counter width.
   always_comb begin
      wr_cnt = CNTW'(WDATA);
      if ({16'd0, WDATA} > CNT_MAX) begin
         wr_cnt = '1;
      end
   end

   // Next-state logic for run control, prescaler, step burst and delay shadows.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path can infer a latch.
      state_d    = state_q;
      div_d      = div_q;
      presc_d    = presc_q;
      stepn_d    = stepn_q;
      remain_d   = remain_q;
      tick_d     = 1'b0;
      stepdone_d = 1'b0;
      pend_d     = pend_q;
      phl_d      = phl_q;
      plh_d      = plh_q;
      phl_sh_d   = phl_sh_q;
      plh_sh_d   = plh_sh_q;
      tcount_d   = tcount_q + 32'(tick_q);

      if (wr_stepn) begin
         stepn_d = WDATA;
      end

      unique case (state_q)
         ST_HALT: begin
            presc_d = '0;
            if (wr_ctrl) begin
               div_d = DIVW'(WDATA[15:8]);
               if (ctrl_run) begin
                  state_d = ST_RUN;
               end else if (ctrl_step) begin
                  if (stepn_q == 16'd0) begin
                     stepdone_d = 1'b1;
                  end else begin
                     state_d  = ST_STEP;
                     remain_d = stepn_q;
                  end
               end
            end
         end

         ST_RUN: begin
            // A write with STEP set and RUN clear is a step request and is dropped whole.
            if (wr_ctrl && !ctrl_run && !ctrl_step) begin
               state_d = ST_HALT;
               div_d   = DIVW'(WDATA[15:8]);
               presc_d = '0;
            end else begin
               if (wr_ctrl && ctrl_run) begin
                  div_d = DIVW'(WDATA[15:8]);
               end
               if (tick_due) begin
                  tick_d  = 1'b1;
                  presc_d = '0;
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
         end

         ST_STEP: begin
            if (wr_ctrl && ctrl_run) begin
               state_d  = ST_RUN;
               div_d    = DIVW'(WDATA[15:8]);
               presc_d  = '0;
               remain_d = '0;
            end else if (wr_ctrl && !ctrl_step) begin
               state_d  = ST_HALT;
               div_d    = DIVW'(WDATA[15:8]);
               presc_d  = '0;
               remain_d = '0;
            end else if (remain_q == 16'd0) begin
               // The last TICK is on the wires this cycle; report completion next.
               state_d    = ST_HALT;
               presc_d    = '0;
               stepdone_d = 1'b1;
            end else if (tick_due) begin
               tick_d   = 1'b1;
               presc_d  = '0;
               remain_d = remain_q - 16'd1;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_HALT;
            presc_d = '0;
         end
      endcase

      // Shadow moves to the live counts while halted, or on the edge closing a TICK cycle.
      if (pend_q && ((state_q == ST_HALT) || tick_q)) begin
         phl_d  = phl_sh_q;
         plh_d  = plh_sh_q;
         pend_d = 1'b0;
      end
      // A write on the application edge lands in the shadow and stays pending.
      if (wr_phl) begin
         phl_sh_d = wr_cnt;
         pend_d   = 1'b1;
      end
      if (wr_plh) begin
         plh_sh_d = wr_cnt;
         pend_d   = 1'b1;
      end
   end

   // State and registered outputs; reset abandons any burst silently.
   always_ff @(posedge U or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_HALT;
         div_q      <= '0;
         presc_q    <= '0;
         stepn_q    <= '0;
         remain_q   <= '0;
         tick_q     <= 1'b0;
         stepdone_q <= 1'b0;
         pend_q     <= 1'b0;
         phl_q      <= CNTW'(PHLRST);
         plh_q      <= CNTW'(PLHRST);
         phl_sh_q   <= CNTW'(PHLRST);
         plh_sh_q   <= CNTW'(PLHRST);
         tcount_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         div_q      <= div_d;
         presc_q    <= presc_d;
         stepn_q    <= stepn_d;
         remain_q   <= remain_d;
         tick_q     <= tick_d;
         stepdone_q <= stepdone_d;
         pend_q     <= pend_d;
         phl_q      <= phl_d;
         plh_q      <= plh_d;
         phl_sh_q   <= phl_sh_d;
         plh_sh_q   <= plh_sh_d;
         tcount_q   <= tcount_d;
      end
   end

   assign TICK      = tick_q;
   assign RUNNING   = (state_q != ST_HALT);
   assign STEPDONE  = stepdone_q;
   assign PEND      = pend_q;
   assign PHLCNT    = phl_q;
   assign PLHCNT    = plh_q;
   assign TICKCOUNT = tcount_q;

endmodule

// File: tb/tb_standcell_tick_sched.sv
// Self-checking bench for standcell_tick_sched. Expected TICK and STEPDONE cycles are
// queued as stimulus is applied and retired as the DUT produces the pulses.
module tb_standcell_tick_sched;

   logic        U = 1'b0;
   logic        RESET = 1'b1;
   logic        WREN = 1'b0;
   logic [1:0]  WADDR = 2'd0;
   logic [15:0] WDATA = 16'd0;
   logic        TICK, RUNNING, STEPDONE, PEND;
   logic [9:0]  PHLCNT, PLHCNT;
   logic [31:0] TICKCOUNT;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_tick[$];
   int exp_done[$];

   standcell_tick_sched dut (
      .U(U), .RESET(RESET), .WREN(WREN), .WADDR(WADDR), .WDATA(WDATA),
      .TICK(TICK), .RUNNING(RUNNING), .STEPDONE(STEPDONE), .PEND(PEND),
      .PHLCNT(PHLCNT), .PLHCNT(PLHCNT), .TICKCOUNT(TICKCOUNT)
   );

   always #5 U = ~U;

   // One clock edge, then retire scoreboard entries against the new cycle's outputs.
   task automatic step_cyc();
      @(posedge U);
      #1;
      cyc++;
      while (exp_tick.size() > 0 && exp_tick[0] < cyc) begin
         n_checks++; n_fail++;
         $display("FAIL tick_missing: TICK expected at cycle %0d missing (checked through cycle %0d)", exp_tick[0], cyc);
         void'(exp_tick.pop_front());
      end
      while (exp_done.size() > 0 && exp_done[0] < cyc) begin
         n_checks++; n_fail++;
         $display("FAIL stepdone_missing: STEPDONE expected at cycle %0d missing (checked through cycle %0d)", exp_done[0], cyc);
         void'(exp_done.pop_front());
      end
      if (TICK !== 1'b0) begin
         n_checks++;
         if (exp_tick.size() > 0 && exp_tick[0] == cyc) void'(exp_tick.pop_front());
         else begin
            n_fail++;
            $display("FAIL tick_unexpected: TICK=%b at cycle %0d, required 0", TICK, cyc);
         end
      end
      if (STEPDONE !== 1'b0) begin
         n_checks++;
         if (exp_done.size() > 0 && exp_done[0] == cyc) void'(exp_done.pop_front());
         else begin
            n_fail++;
            $display("FAIL stepdone_unexpected: STEPDONE=%b at cycle %0d, required 0", STEPDONE, cyc);
         end
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      WREN = 1'b1; WADDR = a; WDATA = d;
      step_cyc();
      WREN = 1'b0;
   endtask

   task automatic do_reset();
      RESET = 1'b1; WREN = 1'b0;
      repeat (2) step_cyc();
      RESET = 1'b0;
   endtask

   task automatic drain(input string tag);
      n_checks++;
      if (exp_tick.size() != 0 || exp_done.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d TICK and %0d STEPDONE still expected, required 0 and 0",
                  tag, exp_tick.size(), exp_done.size());
      end
      exp_tick.delete();
      exp_done.delete();
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 100; i++) begin
         step_cyc();
         n_checks++;
         if (PHLCNT !== 10'd39 || PLHCNT !== 10'd399 || TICKCOUNT !== 32'd0 || RUNNING !== 1'b0 || PEND !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: cycle %0d PHL=%0d PLH=%0d TCNT=%0d RUN=%b PEND=%b, required 39 399 0 0 0",
                     i, PHLCNT, PLHCNT, TICKCOUNT, RUNNING, PEND);
         end
      end
      drain("reset");
   endtask

   task automatic test_run();
      int c0;
      do_reset();
      c0 = cyc + 1;
      for (int k = 1; k <= 4; k++) exp_tick.push_back(c0 + 4 * k);
      wr(2'd0, 16'h0301);
      n_checks++;
      if (RUNNING !== 1'b1) begin n_fail++; $display("FAIL run_running: RUNNING=%b, required 1", RUNNING); end
      repeat (16) step_cyc();
      wr(2'd0, 16'h0000);
      n_checks++;
      if (RUNNING !== 1'b0) begin n_fail++; $display("FAIL run_stop: RUNNING=%b, required 0", RUNNING); end
      n_checks++;
      if (TICKCOUNT !== 32'd4) begin n_fail++; $display("FAIL run_tickcount: TICKCOUNT=%0d, required 4", TICKCOUNT); end
      repeat (12) step_cyc();
      drain("run");
   endtask

   task automatic test_halt_suppress();
      do_reset();
      wr(2'd0, 16'h0301);
      repeat (3) step_cyc();
      wr(2'd0, 16'h0000);   // lands on the edge that would have produced the first TICK
      repeat (8) step_cyc();
      n_checks++;
      if (TICKCOUNT !== 32'd0) begin n_fail++; $display("FAIL suppress_tickcount: TICKCOUNT=%0d, required 0", TICKCOUNT); end
      drain("suppress");
   endtask

   task automatic test_step();
      int c0;
      do_reset();
      wr(2'd1, 16'd5);
      c0 = cyc + 1;
      for (int k = 1; k <= 5; k++) exp_tick.push_back(c0 + k);
      exp_done.push_back(c0 + 6);
      wr(2'd0, 16'h0002);
      repeat (6) step_cyc();
      n_checks++;
      if (TICKCOUNT !== 32'd5) begin n_fail++; $display("FAIL step_tickcount: TICKCOUNT=%0d, required 5", TICKCOUNT); end
      n_checks++;
      if (RUNNING !== 1'b0) begin n_fail++; $display("FAIL step_halted: RUNNING=%b, required 0", RUNNING); end
      repeat (6) step_cyc();
      drain("step");
   endtask

   task automatic test_step_zero();
      do_reset();
      wr(2'd1, 16'd0);
      exp_done.push_back(cyc + 1);
      wr(2'd0, 16'h0002);
      n_checks++;
      if (RUNNING !== 1'b0) begin n_fail++; $display("FAIL stepzero_running: RUNNING=%b, required 0", RUNNING); end
      repeat (6) step_cyc();
      drain("stepzero");
   endtask

   task automatic test_step_ignored_in_run();
      int c0;
      do_reset();
      c0 = cyc + 1;
      for (int k = 1; k <= 6; k++) exp_tick.push_back(c0 + 2 * k);
      wr(2'd0, 16'h0101);
      repeat (4) step_cyc();
      wr(2'd0, 16'h0002);
      n_checks++;
      if (RUNNING !== 1'b1) begin n_fail++; $display("FAIL ignore_running: RUNNING=%b, required 1", RUNNING); end
      repeat (7) step_cyc();
      wr(2'd0, 16'h0000);
      n_checks++;
      if (RUNNING !== 1'b0) begin n_fail++; $display("FAIL ignore_stop: RUNNING=%b, required 0", RUNNING); end
      n_checks++;
      if (TICKCOUNT !== 32'd6) begin n_fail++; $display("FAIL ignore_tickcount: TICKCOUNT=%0d, required 6", TICKCOUNT); end
      repeat (6) step_cyc();
      drain("ignore");
   endtask

   task automatic test_pend();
      int c0;
      do_reset();
      c0 = cyc + 1;
      exp_tick.push_back(c0 + 3);
      exp_tick.push_back(c0 + 6);
      wr(2'd0, 16'h0201);
      repeat (3) step_cyc();
      wr(2'd2, 16'hFFFF);
      n_checks++;
      if (PEND !== 1'b1 || PHLCNT !== 10'd39) begin n_fail++; $display("FAIL pend_set: PEND=%b PHL=%0d, required 1 39", PEND, PHLCNT); end
      repeat (2) step_cyc();
      n_checks++;
      if (TICK !== 1'b1 || PEND !== 1'b1 || PHLCNT !== 10'd39) begin
         n_fail++; $display("FAIL pend_tick_cycle: TICK=%b PEND=%b PHL=%0d, required 1 1 39", TICK, PEND, PHLCNT);
      end
      step_cyc();
      n_checks++;
      if (PEND !== 1'b0 || PHLCNT !== 10'd1023) begin n_fail++; $display("FAIL pend_apply: PEND=%b PHL=%0d, required 0 1023", PEND, PHLCNT); end
      wr(2'd0, 16'h0000);
      drain("pend_run");

      wr(2'd3, 16'd500);
      n_checks++;
      if (PEND !== 1'b1 || PLHCNT !== 10'd399) begin n_fail++; $display("FAIL halt_pend: PEND=%b PLH=%0d, required 1 399", PEND, PLHCNT); end
      step_cyc();
      n_checks++;
      if (PEND !== 1'b0 || PLHCNT !== 10'd500) begin n_fail++; $display("FAIL halt_apply: PEND=%b PLH=%0d, required 0 500", PEND, PLHCNT); end
      wr(2'd3, 16'd1024);
      step_cyc();
      n_checks++;
      if (PLHCNT !== 10'd1023) begin n_fail++; $display("FAIL clamp_1024: PLH=%0d, required 1023", PLHCNT); end
      wr(2'd3, 16'd1000);
      step_cyc();
      n_checks++;
      if (PLHCNT !== 10'd1000) begin n_fail++; $display("FAIL in_range: PLH=%0d, required 1000", PLHCNT); end

      wr(2'd2, 16'd5);
      wr(2'd2, 16'd6);      // same edge as applying 5
      n_checks++;
      if (PHLCNT !== 10'd5 || PEND !== 1'b1) begin n_fail++; $display("FAIL same_edge: PHL=%0d PEND=%b, required 5 1", PHLCNT, PEND); end
      step_cyc();
      n_checks++;
      if (PHLCNT !== 10'd6 || PEND !== 1'b0) begin n_fail++; $display("FAIL last_wins: PHL=%0d PEND=%b, required 6 0", PHLCNT, PEND); end
      drain("pend_halt");
   endtask

   task automatic test_reset_mid_burst();
      int c0;
      do_reset();
      wr(2'd2, 16'd77);
      wr(2'd1, 16'd100);
      c0 = cyc + 1;
      for (int k = 1; k <= 10; k++) exp_tick.push_back(c0 + k);
      wr(2'd0, 16'h0002);
      repeat (10) step_cyc();
      #2;
      RESET = 1'b1;
      #1;
      n_checks++;
      if (TICK !== 1'b0 || RUNNING !== 1'b0 || STEPDONE !== 1'b0 || PEND !== 1'b0 ||
          PHLCNT !== 10'd39 || PLHCNT !== 10'd399 || TICKCOUNT !== 32'd0) begin
         n_fail++;
         $display("FAIL mid_reset: TICK=%b RUN=%b DONE=%b PEND=%b PHL=%0d PLH=%0d TCNT=%0d, required 0 0 0 0 39 399 0",
                  TICK, RUNNING, STEPDONE, PEND, PHLCNT, PLHCNT, TICKCOUNT);
      end
      repeat (2) step_cyc();
      RESET = 1'b0;
      repeat (120) step_cyc();
      n_checks++;
      if (TICKCOUNT !== 32'd0 || RUNNING !== 1'b0) begin
         n_fail++; $display("FAIL post_reset: TCNT=%0d RUN=%b, required 0 0", TICKCOUNT, RUNNING);
      end
      drain("mid_reset");
   endtask

   initial begin
      test_reset();
      test_run();
      test_halt_suppress();
      test_step();
      test_step_zero();
      test_step_ignored_in_run();
      test_pend();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
